// File: rtl/rv_pkg.sv
// Shared types and constants for the instruction fetch stage and its prefetch queue.
package rv_pkg;

    localparam int IF_XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] inst;
    } fetch_entry_t;

    // True for the opcodes the downstream decode controller implements.
    function automatic logic opcode_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_R, OP_LOAD, OP_IMM, OP_JALR,
            OP_STORE, OP_JAL, OP_BRANCH, OP_LUI: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch queue of {pc, inst} entries; flush empties it in one cycle.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    assign empty  = (count_q == '0);
    assign pop_ok = pop && !empty;
    assign head   = mem_q[rd_ptr_q];
    assign count  = count_q;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem request/grant/response handling, prefetch queue, redirect flush.
// Define IFETCH_ILLEGAL_CHECK_EN to flag unsupported opcodes on the head instruction.
module instr_fetch
    import rv_pkg::*;
#(
    parameter int               XLEN     = IF_XLEN,
    parameter int               DEPTH    = 2,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcod,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic            illegal
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic             fifo_push;
    logic             fifo_flush;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_wdata;
    fetch_entry_t     fifo_head;

    logic [CNT_W:0]   occupancy;
    logic             issue_ok;
    logic             grant;
    logic             resp_ok;
    logic [CNT_W-1:0] remaining;
    logic [XLEN-1:0]  target_pc;

    // Slots are reserved at issue time, so a granted word always has room when it returns.
    assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign issue_ok  = (state_q == ST_FETCH) && (occupancy < (CNT_W + 1)'(DEPTH));
    assign imem_req  = issue_ok && !redirect;
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;
    assign resp_ok   = imem_rvalid && (outstanding_q != '0);
    assign remaining = outstanding_q - CNT_W'(resp_ok);
    assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

    assign fifo_pop   = inst_valid && inst_ready;
    assign fifo_wdata = '{pc: resp_pc_q, inst: imem_rdata};

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (grant) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                end
                if (resp_ok) begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + XLEN'(4);
                end
                outstanding_d = remaining + CNT_W'(grant);
            end
            ST_FLUSH: begin
                outstanding_d = remaining;
                discard_d     = discard_q - CNT_W'(resp_ok);
                if (discard_d == '0) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Redirect overrides everything above; words still in flight belong to the old path.
        if (redirect && (state_q != ST_BOOT)) begin
            fifo_push     = 1'b0;
            fifo_flush    = 1'b1;
            fetch_pc_d    = target_pc;
            resp_pc_d     = target_pc;
            outstanding_d = remaining;
            discard_d     = remaining;
            state_d       = (remaining != '0) ? ST_FLUSH : ST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_BOOT;
            fetch_pc_q    <= RESET_PC & ~XLEN'(3);
            resp_pc_q     <= RESET_PC & ~XLEN'(3);
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign inst_valid = !fifo_empty;
    assign inst       = fifo_head.inst;
    assign inst_pc    = fifo_head.pc;
    assign opcod      = fifo_head.inst[6:0];
    assign func3      = fifo_head.inst[14:12];
    assign func7      = fifo_head.inst[31:25];

`ifdef IFETCH_ILLEGAL_CHECK_EN
    assign illegal = inst_valid && !opcode_supported(opcod);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: random-latency memory model, expected-PC stream model, directed corners.
module tb_instr_fetch;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

`ifdef IFETCH_ILLEGAL_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcod;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        illegal;

    instr_fetch #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .opcod       (opcod),
        .func3       (func3),
        .func7       (func7),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int pops    = 0;
    int mem_cyc = 0;
    int gnt_pct = 100;
    int rv_pct  = 100;

    typedef struct {
        logic [31:0] addr;
        int          ready_cyc;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] redir_q[$];
    logic [31:0] mon_e;
    logic [31:0] mon_w;
    logic [31:0] mon_t;

    // Memory contents: a hash of the address, plus two fixed words for the opcode check.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h300) return 32'h0000007F;
        if (a == 32'h304) return 32'h00000013;
        return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A1234;
    endfunction

    function automatic logic model_illegal(input logic [31:0] w);
        logic in_list;
        case (w[6:0])
            7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111,
            7'b0100011, 7'b1101111, 7'b1100011, 7'b0110111: in_list = 1'b1;
            default:                                         in_list = 1'b0;
        endcase
        return CHECK_EN && !in_list;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // In-order memory: random grant, random response delay of at least one cycle.
    initial begin
        forever begin
            @(posedge clk);
            mem_cyc++;
            #1;
            imem_gnt = ($urandom_range(0, 99) < gnt_pct);
            if (pend_q.size() > 0 && pend_q[0].ready_cyc <= mem_cyc && $urandom_range(0, 99) < rv_pct) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_q[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            @(negedge clk);
            if (imem_rvalid) pend_q.pop_front();
            if (rst && imem_req && imem_gnt) pend_q.push_back('{addr: imem_addr, ready_cyc: mem_cyc + 1});
        end
    end

    // Monitor: every accepted instruction must be the next PC of the current path.
    always @(negedge clk) begin
        if (rst) begin
            if (inst_valid && inst_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pop actual_pc=0x%08h expected=none", inst_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (exp_q.size() == 0) exp_q.push_back(mon_e + 32'd4);
                    mon_w = mem_word(mon_e);
                    check_output("pop_pc", inst_pc, mon_e);
                    check_output("pop_inst", inst, mon_w);
                    check_output("pop_fields", {15'b0, func7, func3, opcod},
                                 {15'b0, mon_w[31:25], mon_w[14:12], mon_w[6:0]});
                    check_output("pop_illegal", 32'(illegal), 32'(model_illegal(mon_w)));
                end
            end
            if (redirect) begin
                mon_t = (redir_q.size() > 0) ? redir_q.pop_front() : redirect_pc;
                exp_q.delete();
                exp_q.push_back({mon_t[31:2], 2'b00});
            end
        end
    end

    task automatic apply_stimulus_redirect(input logic [31:0] t);
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = t;
        redir_q.push_back(t);
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit          found;
        logic [31:0] t;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_imem_req", 32'(imem_req), 32'd0);
        check_output("rst_imem_addr", imem_addr, RESET_PC);
        check_output("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_output("rst_inst", inst, 32'd0);
        check_output("rst_inst_pc", inst_pc, 32'd0);
        check_output("rst_fields", {15'b0, func7, func3, opcod}, 32'd0);
        check_output("rst_illegal", 32'(illegal), 32'd0);

        // Release reset with a one-cycle memory and an always-ready consumer.
        @(posedge clk);
        #1;
        exp_q.push_back(RESET_PC);
        rst = 1'b1;
        @(negedge clk);
        check_output("boot_no_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        check_output("first_req", 32'(imem_req), 32'd1);
        check_output("first_addr", imem_addr, RESET_PC);
        @(negedge clk);
        check_output("cycle2_no_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        check_output("cycle3_valid", 32'(inst_valid), 32'd1);
        check_output("cycle3_pc", inst_pc, RESET_PC);
        wait_cycles(6);

        // Consumer stall: queue fills to DEPTH and requests stop.
        inst_ready = 1'b0;
        wait_cycles(5);
        @(negedge clk);
        check_output("stall_req_low", 32'(imem_req), 32'd0);
        check_output("stall_valid", 32'(inst_valid), 32'd1);
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        wait_cycles(6);

        // Grant withheld: address must hold at the next sequential PC.
        gnt_pct = 0;
        wait_cycles(6);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("nognt_req", 32'(imem_req), 32'd1);
            check_output("nognt_addr", imem_addr, exp_q[0]);
            check_output("nognt_no_valid", 32'(inst_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        gnt_pct = 100;

        // Redirect with two requests outstanding and no responses yet.
        rv_pct = 0;
        wait_cycles(6);
        apply_stimulus_redirect(32'h103);
        rv_pct = 100;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (inst_valid) found = 1'b1;
        end
        check_output("redir103_seen", 32'(found), 32'd1);
        if (found) check_output("redir103_pc", inst_pc, 32'h100);
        wait_cycles(6);

        // Redirect landing in the same cycle as a response and a pop.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #2;
            if (inst_valid && imem_rvalid) found = 1'b1;
        end
        check_output("coincide_found", 32'(found), 32'd1);
        if (found) begin
            redirect    = 1'b1;
            redirect_pc = 32'h200;
            redir_q.push_back(32'h200);
            @(posedge clk);
            #1;
            redirect = 1'b0;
            found    = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                if (imem_req) found = 1'b1;
            end
            check_output("coincide_req_seen", 32'(found), 32'd1);
            check_output("coincide_next_addr", imem_addr, 32'h200);
        end
        wait_cycles(6);

        // Opcode check on known words at 0x300 / 0x304.
        apply_stimulus_redirect(32'h300);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (inst_valid) found = 1'b1;
        end
        check_output("illegal_word_seen", 32'(found), 32'd1);
        if (found) begin
            check_output("illegal_word_pc", inst_pc, 32'h300);
            check_output("illegal_7f", 32'(illegal), 32'(CHECK_EN));
        end
        wait_cycles(8);

        // Randomised traffic, redirects (some near the top of the address space) and stalls.
        gnt_pct = 70;
        rv_pct  = 70;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            redirect   = 1'b0;
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                t = ($urandom_range(0, 5) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
                redirect    = 1'b1;
                redirect_pc = t;
                redir_q.push_back(t);
            end
        end
        @(posedge clk);
        #1;
        redirect   = 1'b0;
        inst_ready = 1'b1;
        gnt_pct    = 100;
        rv_pct     = 100;
        wait_cycles(30);
        check_output("liveness_pops", 32'(pops >= 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
